// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Serialises words from a show-ahead FIFO into UART frames, one serial bit
// per clk cycle:  start(0) | DATA_WIDTH data bits, LSB first | optional
// parity | stop(1).  The word and its framing options are captured on the
// pop cycle, so the FIFO and the parity controls are free to change while a
// frame is on the line.  A pop during the stop bit chains the next frame
// with no idle gap.
//
// Ports
//   clk         transmit/baud clock, one serial bit per cycle
//   rst         asynchronous, active-low reset
//   fifo_empty  FIFO read-side empty flag (synchronous to clk)
//   fifo_rdata  word at the FIFO read address, valid while fifo_empty=0
//   par_en      1 = insert a parity bit after the data bits
//   par_typ     0 = even parity, 1 = odd parity
//   fifo_inc    pop strobe to the FIFO read pointer (combinational)
//   tx_out      registered serial line, idle high
//   busy        registered, high while a frame is in progress
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  fifo_inc,
  output logic                  tx_out,
  output logic                  busy
);

  // Counter needs at least one bit even for a 1-bit payload.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_reg,   state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] data_reg,    data_next;
  logic                  par_en_reg,  par_en_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  tx_reg,      tx_next;
  logic                  busy_reg,    busy_next;

  logic                  pop;
  logic [CNT_W-1:0]      bit_cnt_inc;

  // A word is taken only when the line can accept a new frame (idle, or the
  // last cycle of the current frame).  Gating with rst keeps the strobe low
  // while reset is held, even though the FIFO may report data.
  assign pop         = rst && !fifo_empty && ((state_reg == IDLE) || (state_reg == STOP));
  assign fifo_inc    = pop;
  assign bit_cnt_inc = bit_cnt_reg + 1'b1;

  assign tx_out = tx_reg;
  assign busy   = busy_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      data_reg    <= data_next;
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

  // tx_next/busy_next describe the state being entered, so the line bit is
  // registered on the same edge as the state change.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    data_next    = data_reg;
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (pop) begin
          state_next   = START;
          data_next    = fifo_rdata;
          par_en_next  = par_en;
          par_bit_next = (^fifo_rdata) ^ par_typ;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
        end
      end

      START: begin
        state_next   = DATA;
        bit_cnt_next = '0;
        tx_next      = data_reg[0];
        busy_next    = 1'b1;
      end

      DATA: begin
        busy_next = 1'b1;
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_next = '0;
          if (par_en_reg) begin
            state_next = PARITY;
            tx_next    = par_bit_reg;
          end else begin
            state_next = STOP;
            tx_next    = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt_inc;
          tx_next      = data_reg[bit_cnt_inc];
        end
      end

      PARITY: begin
        state_next = STOP;
        tx_next    = 1'b1;
        busy_next  = 1'b1;
      end

      STOP: begin
        if (pop) begin
          // Chain straight into the next frame's start bit.
          state_next   = START;
          data_next    = fifo_rdata;
          par_en_next  = par_en;
          par_bit_next = (^fifo_rdata) ^ par_typ;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
        end else begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        tx_next      = 1'b1;
        busy_next    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Directed bench for fifo_uart_tx (DATA_WIDTH = 8).  A frame-level model
// turns each accepted word into its list of line bits; a negedge process
// compares tx_out, busy and fifo_inc against it every cycle.  Directed
// scenarios additionally pin captured frames to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          par_en;
  logic          par_typ;
  logic          fifo_inc;
  logic          tx_out;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fifo_uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .fifo_inc   (fifo_inc),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  // m_tx is the bit on the line now; m_q holds the rest of the frame.
  // The last bit of a frame is the stop bit, which is when a new word may
  // be accepted.
  logic m_tx   = 1'b1;
  logic m_busy = 1'b0;
  bit   m_q[$];

  function automatic logic model_inc();
    return rst && !fifo_empty && (!m_busy || (m_q.size() == 0));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_q.delete();
    end else if (model_inc()) begin
      m_q.delete();
      for (int i = 0; i < DW; i++) m_q.push_back(fifo_rdata[i]);
      if (par_en) m_q.push_back((($countones(fifo_rdata) % 2) == 1) != par_typ);
      m_q.push_back(1'b1);
      m_tx   = 1'b0;
      m_busy = 1'b1;
    end else if (m_q.size() != 0) begin
      m_tx = m_q.pop_front();
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_tx_out", {31'd0, tx_out}, {31'd0, m_tx});
    chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("model_fifo_inc", {31'd0, fifo_inc}, {31'd0, model_inc()});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, confirm it is popped immediately, then capture n line
  // bits and the number of busy cycles, and confirm the line goes idle.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input int n, output logic [15:0] seq, output int busy_cnt);
    step();
    fifo_rdata = d;
    par_en     = pe;
    par_typ    = pt;
    fifo_empty = 1'b0;
    @(negedge clk);
    chk("pop_strobe", {31'd0, fifo_inc}, 32'd1);
    step();
    fifo_empty = 1'b1;
    seq      = '0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seq[i] = tx_out;
      if (busy) busy_cnt++;
    end
    @(negedge clk);
    chk("idle_after_frame", {30'd0, busy, tx_out}, 32'd1);
  endtask

  logic [15:0] seq;
  int          bcnt;
  int          p1, p2;
  bit          found;

  initial begin
    rst        = 1'b1;
    fifo_empty = 1'b0;
    fifo_rdata = 8'h55;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #2 rst = 1'b0;

    // Reset held with data available: no pops, line idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_hold", {29'd0, fifo_inc, busy, tx_out}, 32'd1);
    end
    step();
    fifo_empty = 1'b1;
    rst        = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, no parity: 10-bit frame.
    send_frame(8'hA5, 1'b0, 1'b0, 10, seq, bcnt);
    chk("a5_frame_bits", {16'd0, seq}, 32'h34A);
    chk("a5_frame_len", bcnt, 10);

    // 0xA5 with even and odd parity: 11-bit frames.
    send_frame(8'hA5, 1'b1, 1'b0, 11, seq, bcnt);
    chk("a5_even_bits", {16'd0, seq}, 32'h54A);
    chk("a5_even_len", bcnt, 11);
    send_frame(8'hA5, 1'b1, 1'b1, 11, seq, bcnt);
    chk("a5_odd_bits", {16'd0, seq}, 32'h74A);
    chk("a5_odd_len", bcnt, 11);

    // Back-to-back 0x01 then 0x80: second pop in the stop bit.
    step();
    fifo_rdata = 8'h01;
    par_en     = 1'b0;
    fifo_empty = 1'b0;
    @(negedge clk);
    chk("b2b_pop1", {31'd0, fifo_inc}, 32'd1);
    p1 = cyc;
    step();
    fifo_rdata = 8'h80;
    found = 1'b0;
    bcnt  = 0;
    p2    = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (fifo_inc) begin
        found = 1'b1;
        p2    = cyc;
        chk("b2b_stop_before_start", {31'd0, tx_out}, 32'd1);
      end
    end
    chk("b2b_pop2_seen", {31'd0, found}, 32'd1);
    chk("b2b_pop_spacing", p2 - p1, 10);
    step();
    fifo_empty = 1'b1;
    chk("b2b_start_follows", {31'd0, tx_out}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      else found = 1'b1;
    end
    chk("b2b_busy_cycles", bcnt, 20);

    // Reset during data bit 3 of 0xC3.
    step();
    fifo_rdata = 8'hC3;
    fifo_empty = 1'b0;
    @(negedge clk);
    chk("rst_mid_pop", {31'd0, fifo_inc}, 32'd1);
    step();
    fifo_empty = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_immediate", {29'd0, fifo_inc, busy, tx_out}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_mid_after", {29'd0, fifo_inc, busy, tx_out}, 32'd1);
    end

    // Options and data change mid-frame; frame keeps 0x3C, even parity.
    step();
    fifo_rdata = 8'h3C;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    fifo_empty = 1'b0;
    @(negedge clk);
    chk("mid_change_pop", {31'd0, fifo_inc}, 32'd1);
    step();
    fifo_empty = 1'b1;
    seq = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      seq[i] = tx_out;
      @(posedge clk);
      #1;
      par_en     = ~par_en;
      par_typ    = ~par_typ;
      fifo_rdata = 8'($urandom);
    end
    @(negedge clk);
    chk("mid_change_idle", {31'd0, busy}, 32'd0);
    chk("mid_change_bits", {16'd0, seq}, 32'h478);

    // Next frame takes the values present at its own pop: 0x5A, odd parity.
    send_frame(8'h5A, 1'b1, 1'b1, 11, seq, bcnt);
    chk("next_frame_bits", {16'd0, seq}, 32'h6B4);
    chk("next_frame_len", bcnt, 11);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
